// File: rtl/core_host_ctrl.sv
// core_host_ctrl: preloads core data memory, pulses core_req, waits for core_done, streams results back
module core_host_ctrl #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int LOAD_BASE = 0,
  parameter int LOAD_N    = 4,
  parameter int RES_BASE  = 64,
  parameter int RES_N     = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          timeout_err,
  output logic [15:0]   cycle_count,
  output logic          core_req,
  input  logic          core_done,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_data,
  input  logic [DW-1:0] mem_rd_data
);
  localparam int MAXN = LOAD_N > RES_N ? LOAD_N : RES_N;
  localparam int IW   = MAXN > 0 ? $clog2(MAXN + 1) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, REQ, RUN, READ} state_t;
  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic          armed, armed_n;
  logic [15:0]   cnt, cnt_n;
  logic          terr, terr_n;
  logic [AW-1:0] ld_addr, rd_addr;
  assign ld_addr     = AW'(LOAD_BASE) + AW'(idx);
  assign rd_addr     = AW'(RES_BASE) + AW'(idx);
  assign busy        = state != IDLE;
  assign cycle_count = cnt;
  assign timeout_err = terr;
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    armed_n     = armed;
    cnt_n       = cnt;
    terr_n      = terr;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    core_req    = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    case (state)
      IDLE: if (start) begin
        terr_n  = 1'b0;
        cnt_n   = '0;
        idx_n   = '0;
        state_n = LOAD_N == 0 ? REQ : LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        mem_addr = ld_addr;
        if (in_valid) begin
          mem_wr_en   = 1'b1;
          mem_wr_data = in_data;
          idx_n       = idx + 1'b1;
          state_n     = int'(idx) == LOAD_N - 1 ? REQ : LOAD;
        end
      end
      REQ: begin
        core_req = 1'b1;
        armed_n  = 1'b0;
        cnt_n    = '0;
        state_n  = RUN;
      end
      // a done level left over from the previous job only counts after it has been seen low
      RUN: if (armed && core_done) begin
        idx_n   = '0;
        state_n = RES_N == 0 ? IDLE : READ;
      end else begin
        armed_n = armed | ~core_done;
        cnt_n   = &cnt ? cnt : cnt + 16'd1;
        if (int'(cnt) == TIMEOUT - 1) begin
          terr_n  = 1'b1;
          state_n = IDLE;
        end
      end
      READ: begin
        out_valid = 1'b1;
        mem_addr  = rd_addr;
        out_data  = mem_rd_data;
        if (out_ready) begin
          idx_n   = idx + 1'b1;
          state_n = int'(idx) == RES_N - 1 ? IDLE : READ;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      armed <= 1'b0;
      cnt   <= '0;
      terr  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      armed <= armed_n;
      cnt   <= cnt_n;
      terr  <= terr_n;
    end
  end
endmodule

// File: tb/tb_core_host_ctrl.sv
// tb_core_host_ctrl: randomized jobs against a scoreboard of expected writes, result bytes and job status
module tb_core_host_ctrl;
  localparam int TO = 16;
  localparam int NL = 4;
  logic       clk, reset, start, in_valid, in_ready, out_valid, out_ready;
  logic       busy, timeout_err, core_req, core_done, mem_wr_en;
  logic [7:0] in_data, out_data, mem_addr, mem_wr_data, mem_rd_data;
  logic [15:0] cycle_count;
  logic [7:0] mem [256];
  logic [7:0] res0, res1;
  int         job_pre, job_lo, rdy_pct, n_cmp, n_err;
  bit         stall_mode;
  typedef struct { int cnt; bit terr; } job_t;
  typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
  job_t       jq[$];
  wr_t        wq[$];
  logic [7:0] oq[$];

  core_host_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .timeout_err(timeout_err), .cycle_count(cycle_count), .core_req(core_req),
    .core_done(core_done), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // data memory; the "core" deposits its results at req time
  assign mem_rd_data = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    if (core_req) begin
      mem[64] <= res0;
      mem[65] <= res1;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // core: done high for job_pre RUN cycles, low for job_lo, then high
  initial begin
    int k;
    bit act;
    k = 0;
    act = 0;
    core_done = 0;
    forever begin
      @(posedge clk); #1;
      if (core_req) begin
        k = 0;
        act = 1;
      end else if (act) begin
        k++;
        core_done = k <= job_pre ? 1'b1 : k <= job_pre + job_lo ? 1'b0 : 1'b1;
      end
    end
  end

  initial begin
    int st;
    bit did;
    st = 0;
    did = 0;
    out_ready = 0;
    forever begin
      @(posedge clk); #1;
      if (!busy) did = 0;
      if (stall_mode && out_valid && !did) begin
        st = 3;
        did = 1;
      end
      out_ready = st > 0 ? 1'b0 : ($urandom_range(1, 100) <= rdy_pct);
      if (st > 0) st--;
    end
  end

  initial begin
    bit pb, stalled, seen;
    int reqs, after;
    logic [7:0] held, e;
    wr_t w;
    job_t j;
    pb = 0; stalled = 0; seen = 0; reqs = 0; after = 0; held = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        wq.delete(); oq.delete(); jq.delete();
        pb = 0; stalled = 0;
        continue;
      end
      if (busy && !pb) begin
        reqs = 0; after = 0; seen = 0;
      end
      if (core_req) begin
        reqs++;
        seen = 1;
      end else if (busy && seen) after++;
      if (mem_wr_en) begin
        chk("wr_queue", wq.size() > 0, 1);
        if (wq.size() > 0) begin
          w = wq.pop_front();
          chk("wr_addr", mem_addr, w.a);
          chk("wr_data", mem_wr_data, w.d);
        end
      end
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        if (out_valid) chk("stall_data", out_data, held);
      end
      if (out_valid && out_ready) begin
        chk("out_queue", oq.size() > 0, 1);
        if (oq.size() > 0) begin
          e = oq.pop_front();
          chk("out_data", out_data, e);
        end
      end
      if (pb && !busy) begin
        chk("job_queue", jq.size() > 0, 1);
        if (jq.size() > 0) begin
          j = jq.pop_front();
          chk("cycle_count", cycle_count, j.cnt);
          chk("timeout_err", timeout_err, j.terr);
          chk("req_pulses", reqs, 1);
          chk("results_left", oq.size(), 0);
          if (j.terr) chk("run_cycles", after, TO);
        end
      end
      stalled = out_valid && !out_ready;
      held = out_data;
      pb = busy;
    end
  end

  task automatic check_zero();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_core_req", core_req, 0);
    chk("rst_mem_wr_en", mem_wr_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wr_data", mem_wr_data, 0);
  endtask

  task automatic run_job(input int pre, input int lo, input bit gap, input bit poke,
                         input bit stall, input bit first_lat, input logic [7:0] r0,
                         input logic [7:0] r1);
    logic [7:0] b[NL];
    bit ok, acc;
    int i, t;
    job_t j;
    wr_t w;
    ok = lo > 0 && pre + lo < TO;
    j.cnt = ok ? pre + lo : TO;
    j.terr = !ok;
    jq.push_back(j);
    for (int n = 0; n < NL; n++) begin
      b[n] = 8'($urandom);
      w.a = 8'(n);
      w.d = b[n];
      wq.push_back(w);
    end
    if (ok) begin
      oq.push_back(r0);
      oq.push_back(r1);
    end
    res0 = r0; res1 = r1; job_pre = pre; job_lo = lo; stall_mode = stall;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("start_cnt_clr", cycle_count, 0);
    chk("start_terr_clr", timeout_err, 0);
    chk("load_ready", in_ready, 1);
    i = 0;
    t = 0;
    while (i < NL && t < 200) begin
      in_valid = gap ? t % 2 == 0 : 1'b1;
      in_data = in_valid ? b[i] : 8'($urandom);
      #1;
      if (first_lat && t == 0) chk("first_wr_lat", mem_wr_en, 1);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      t++;
    end
    in_valid = 0;
    chk("load_done", i, NL);
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      chk("poke_busy", busy, 1);
      start = 1;
      @(posedge clk); #1;
      start = 0;
    end
    t = 0;
    while (busy && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("job_end", busy, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b0, b1;
    wr_t w;
    n_cmp = 0; n_err = 0;
    reset = 1; start = 0; in_valid = 0; in_data = 0;
    res0 = 0; res1 = 0; job_pre = 0; job_lo = 1; rdy_pct = 100; stall_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check_zero();
    reset = 0;
    @(posedge clk); #1;
    run_job(0, 10, 0, 0, 0, 1, 8'hA5, 8'h5A);
    run_job(2, 5, 0, 0, 0, 0, 8'($urandom), 8'($urandom));
    run_job(0, 3, 1, 0, 1, 0, 8'($urandom), 8'($urandom));
    run_job(0, 100, 0, 0, 0, 0, 8'h11, 8'h22);
    repeat (3) @(posedge clk);
    #1;
    chk("terr_hold", timeout_err, 1);
    chk("cnt_hold", cycle_count, TO);
    run_job(0, 8, 0, 1, 0, 0, 8'($urandom), 8'($urandom));
    // abort two bytes into LOAD, then a fresh job must reload from the base address
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    w.a = 0; w.d = b0; wq.push_back(w);
    w.a = 1; w.d = b1; wq.push_back(w);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    in_valid = 1; in_data = b0;
    @(posedge clk); #1;
    in_data = b1;
    @(posedge clk); #1;
    in_valid = 0;
    chk("mid_load_busy", busy, 1);
    #2 reset = 1;
    #1 check_zero();
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    run_job(1, 4, 0, 0, 0, 1, 8'($urandom), 8'($urandom));
    for (int n = 0; n < 12; n++) begin
      rdy_pct = $urandom_range(40, 100);
      run_job($urandom_range(0, 3), $urandom_range(0, 14), 1'($urandom), 0, 1'($urandom), 0,
              8'($urandom), 8'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
